// File: rtl/bip_control.sv
// bip_control: program counter, instruction decode, run cycle counter and start/halt FSM for a one-instruction-per-clock CPU
module bip_control #(
  parameter int PC_BITS    = 11,
  parameter int PROG_DEPTH = 30,
  parameter int CNT_BITS   = 32
)(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [15:0]         instr,
  output logic [PC_BITS-1:0]  pc_addr,
  output logic [10:0]         operand,
  output logic [1:0]          sel_a,
  output logic                sel_b,
  output logic                alu_op,
  output logic                wr_acc,
  output logic                wr_ram,
  output logic                rd_ram,
  output logic                running,
  output logic                halted,
  output logic [CNT_BITS-1:0] cycle_count
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t state, state_n;
  logic [PC_BITS-1:0] pc_n;
  logic [CNT_BITS-1:0] cnt_n;
  logic [4:0] op;
  logic run;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state       <= IDLE;
      pc_addr     <= '0;
      cycle_count <= '0;
    end else begin
      state       <= state_n;
      pc_addr     <= pc_n;
      cycle_count <= cnt_n;
    end
  always_comb begin
    state_n = state;
    pc_n    = pc_addr;
    cnt_n   = cycle_count;
    case (state)
      IDLE: begin
        pc_n = '0;
        if (start) begin
          state_n = RUN;
          cnt_n   = '0;
        end
      end
      RUN: begin
        cnt_n = &cycle_count ? cycle_count : cycle_count + CNT_BITS'(1);
        if (op == 5'd0) state_n = HALT;
        else pc_n = (pc_addr == PC_BITS'(PROG_DEPTH - 1)) ? '0 : pc_addr + PC_BITS'(1);
      end
      HALT: if (start) begin
        state_n = IDLE;
        pc_n    = '0;
      end
      default: state_n = IDLE;
    endcase
  end
  assign op      = instr[15:11];
  assign operand = instr[10:0];
  assign running = state == RUN;
  assign halted  = state == HALT;
  assign run     = running;
  // ops 4..7 share prefix 001: bit0 picks immediate operand, bit1 picks subtract
  assign sel_a  = !run ? 2'd0 : (op == 5'd3) ? 2'd1 : (op[4:2] == 3'b001) ? 2'd2 : 2'd0;
  assign sel_b  = run && op[4:2] == 3'b001 && op[0];
  assign alu_op = run && op[4:1] == 4'b0011;
  assign wr_acc = run && op[4:3] == 2'b00 && op[2:1] != 2'b00;
  assign wr_ram = run && op == 5'd1;
  assign rd_ram = run && (op == 5'd2 || (op[4:2] == 3'b001 && !op[0]));
endmodule

// File: tb/tb_bip_control.sv
// tb_bip_control: directed tests of bip_control with a behavioural program memory read on negedge
module tb_bip_control;
  logic        clk = 0, reset = 0, start = 0, use_mem = 1;
  logic [15:0] instr = 16'h0;
  logic [10:0] pc_addr, operand;
  logic [1:0]  sel_a;
  logic        sel_b, alu_op, wr_acc, wr_ram, rd_ram, running, halted;
  logic [31:0] cycle_count;
  logic [15:0] mem [0:31];
  int n_checks = 0, n_fail = 0;

  bip_control dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr), .pc_addr(pc_addr),
    .operand(operand), .sel_a(sel_a), .sel_b(sel_b), .alu_op(alu_op),
    .wr_acc(wr_acc), .wr_ram(wr_ram), .rd_ram(rd_ram), .running(running),
    .halted(halted), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (use_mem) instr <= mem[pc_addr[4:0]];

  function automatic logic [15:0] mk(input logic [4:0] op, input logic [10:0] opd);
    return {op, opd};
  endfunction

  function automatic logic [6:0] ctl();
    return {sel_a, sel_b, alu_op, wr_acc, wr_ram, rd_ram};
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    start = 0;
    reset = 1;
    #2;
    @(negedge clk);
    reset = 0;
    #1;
  endtask

  task automatic load_prog1();
    for (int i = 0; i < 32; i++) mem[i] = mk(5'h1F, 11'd0);
    mem[0] = mk(5'd3, 11'd5);
    mem[1] = mk(5'd5, 11'd3);
    mem[2] = mk(5'd1, 11'd10);
    mem[3] = mk(5'd0, 11'd0);
  endtask

  task automatic test_reset();
    load_prog1();
    do_reset();
    n_checks++;
    if ({pc_addr, running, halted} !== {11'd0, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_state: pc=%0d run=%0b halt=%0b, need pc=0 run=0 halt=0", pc_addr, running, halted);
    end
    n_checks++;
    if (cycle_count !== 32'd0 || ctl() !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: count=%0d ctl=%b, need 0 and 0000000", cycle_count, ctl());
    end
  endtask

  task automatic test_program();
    logic [6:0] exp_ctl [0:3];
    exp_ctl = '{7'b0100100, 7'b1010100, 7'b0000010, 7'b0000000};
    load_prog1();
    do_reset();
    start = 1;
    cyc();
    start = 0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (pc_addr !== 11'(k) || ctl() !== exp_ctl[k] || running !== 1'b1) begin
        n_fail++;
        $display("FAIL prog_step%0d: pc=%0d ctl=%b run=%0b, need pc=%0d ctl=%b run=1", k, pc_addr, ctl(), running, k, exp_ctl[k]);
      end
      cyc();
    end
    n_checks++;
    if (operand !== 11'd0 || pc_addr !== 11'd3 || halted !== 1'b1 || cycle_count !== 32'd4 || ctl() !== 7'd0) begin
      n_fail++;
      $display("FAIL prog_halt: pc=%0d halt=%0b count=%0d ctl=%b, need pc=3 halt=1 count=4 ctl=0", pc_addr, halted, cycle_count, ctl());
    end
    cyc();
    cyc();
    n_checks++;
    if (pc_addr !== 11'd3 || halted !== 1'b1 || cycle_count !== 32'd4) begin
      n_fail++;
      $display("FAIL prog_hold: pc=%0d halt=%0b count=%0d, need pc=3 halt=1 count=4", pc_addr, halted, cycle_count);
    end
  endtask

  task automatic test_decode_sweep();
    logic [4:0] ops [0:8];
    logic [6:0] exp_ctl [0:8];
    ops     = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'h1F, 5'd0};
    exp_ctl = '{7'b0000010, 7'b0000101, 7'b0100100, 7'b1000101, 7'b1010100,
                7'b1001101, 7'b1011100, 7'b0000000, 7'b0000000};
    for (int i = 0; i < 32; i++) mem[i] = mk(5'd0, 11'd0);
    for (int i = 0; i < 9; i++) mem[i] = mk(ops[i], 11'(i * 100 + 7));
    do_reset();
    start = 1;
    cyc();
    start = 0;
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if (ctl() !== exp_ctl[i] || pc_addr !== 11'(i) || operand !== 11'(i * 100 + 7)) begin
        n_fail++;
        $display("FAIL decode_op%0h: ctl=%b pc=%0d opd=%0d, need ctl=%b pc=%0d opd=%0d",
                 ops[i], ctl(), pc_addr, operand, exp_ctl[i], i, i * 100 + 7);
      end
      cyc();
    end
    n_checks++;
    if (halted !== 1'b1 || pc_addr !== 11'd8 || cycle_count !== 32'd9) begin
      n_fail++;
      $display("FAIL decode_halt: halt=%0b pc=%0d count=%0d, need halt=1 pc=8 count=9", halted, pc_addr, cycle_count);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 32; i++) mem[i] = mk(5'd3, 11'(i));
    do_reset();
    start = 1;
    cyc();
    start = 0;
    for (int k = 0; k < 29; k++) cyc();
    n_checks++;
    if (pc_addr !== 11'd29 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_last: pc=%0d run=%0b, need pc=29 run=1", pc_addr, running);
    end
    cyc();
    n_checks++;
    if (pc_addr !== 11'd0 || running !== 1'b1 || cycle_count !== 32'd30 || operand !== 11'd0) begin
      n_fail++;
      $display("FAIL wrap_zero: pc=%0d run=%0b count=%0d opd=%0d, need pc=0 run=1 count=30 opd=0", pc_addr, running, cycle_count, operand);
    end
  endtask

  task automatic test_reset_mid_run();
    load_prog1();
    do_reset();
    start = 1;
    cyc();
    start = 0;
    cyc();
    cyc();
    n_checks++;
    if (pc_addr !== 11'd2 || wr_ram !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_pre: pc=%0d wr_ram=%0b, need pc=2 wr_ram=1", pc_addr, wr_ram);
    end
    reset = 1;
    #1;
    n_checks++;
    if (wr_acc !== 1'b0 || wr_ram !== 1'b0 || pc_addr !== 11'd0 || running !== 1'b0 || cycle_count !== 32'd0) begin
      n_fail++;
      $display("FAIL midrun_reset: wr_acc=%0b wr_ram=%0b pc=%0d run=%0b count=%0d, need all 0",
               wr_acc, wr_ram, pc_addr, running, cycle_count);
    end
    @(negedge clk);
    reset = 0;
    #1;
  endtask

  task automatic test_back_to_back();
    load_prog1();
    do_reset();
    start = 1;
    cyc();
    start = 0;
    for (int k = 0; k < 4; k++) cyc();
    start = 1;
    cyc();
    n_checks++;
    if (running !== 1'b0 || halted !== 1'b0 || pc_addr !== 11'd0 || cycle_count !== 32'd4) begin
      n_fail++;
      $display("FAIL restart_idle: run=%0b halt=%0b pc=%0d count=%0d, need run=0 halt=0 pc=0 count=4", running, halted, pc_addr, cycle_count);
    end
    cyc();
    start = 0;
    n_checks++;
    if (running !== 1'b1 || pc_addr !== 11'd0 || cycle_count !== 32'd0 || ctl() !== 7'b0100100) begin
      n_fail++;
      $display("FAIL restart_run: run=%0b pc=%0d count=%0d ctl=%b, need run=1 pc=0 count=0 ctl=0100100", running, pc_addr, cycle_count, ctl());
    end
    for (int k = 0; k < 4; k++) cyc();
    n_checks++;
    if (halted !== 1'b1 || pc_addr !== 11'd3 || cycle_count !== 32'd4) begin
      n_fail++;
      $display("FAIL restart_halt: halt=%0b pc=%0d count=%0d, need halt=1 pc=3 count=4", halted, pc_addr, cycle_count);
    end
  endtask

  task automatic test_idle_gating();
    do_reset();
    use_mem = 0;
    instr = mk(5'd1, 11'd42);
    for (int k = 0; k < 3; k++) begin
      cyc();
      n_checks++;
      if (wr_ram !== 1'b0 || pc_addr !== 11'd0 || running !== 1'b0 || operand !== 11'd42) begin
        n_fail++;
        $display("FAIL idle_gate%0d: wr_ram=%0b pc=%0d run=%0b opd=%0d, need wr_ram=0 pc=0 run=0 opd=42", k, wr_ram, pc_addr, running, operand);
      end
    end
    use_mem = 1;
  endtask

  initial begin
    test_reset();
    test_program();
    test_decode_sweep();
    test_wrap();
    test_reset_mid_run();
    test_back_to_back();
    test_idle_gating();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
